lpif_tx_arbiter: RTL and testbench

- Link-layer-side transmit scheduler for the LPIF transmit bus (lp_data/lp_valid/lp_irdy with pl_trdy).
- Shares the bus between two requesters, a TLP source and a DLLP source, with packet-atomic arbitration: DLLP has priority, and a starvation limit bounds how long a TLP can wait.
- Gates new packets on the physical-layer state and drives the framing masks toward the PHY through a one-entry registered output stage.

---
 rtl/lpif_tx_arbiter_if.sv | 54 +++++
 rtl/lpif_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_lpif_tx_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpif_tx_arbiter_if.sv
// LPIF transmit-side signal bundle: source request/ack pairs, PHY status and the framed output bus.
// master = arbiter view, slave = environment view (sources + PHY).
interface lpif_tx_arbiter_if #(
  parameter int BUS_WIDTH = 32
);
  localparam int NB = BUS_WIDTH / 8;

  logic [3:0]           pl_state_sts;
  logic                 pl_trdy;

  logic                 tlp_req;
  logic [BUS_WIDTH-1:0] tlp_data;
  logic [NB-1:0]        tlp_valid;
  logic [NB-1:0]        tlp_sop;
  logic [NB-1:0]        tlp_eop;
  logic                 tlp_ack;

  logic                 dllp_req;
  logic [BUS_WIDTH-1:0] dllp_data;
  logic [NB-1:0]        dllp_valid;
  logic [NB-1:0]        dllp_sop;
  logic [NB-1:0]        dllp_eop;
  logic                 dllp_ack;

  logic                 lp_irdy;
  logic [BUS_WIDTH-1:0] lp_data;
  logic [NB-1:0]        lp_valid;
  logic [NB-1:0]        lp_tlp_start;
  logic [NB-1:0]        lp_tlp_end;
  logic [NB-1:0]        lp_dllp_start;
  logic [NB-1:0]        lp_dllp_end;
  logic [NB-1:0]        lp_tlpedb;
  logic                 tx_abort;

  modport master (
    input  pl_state_sts, pl_trdy,
    input  tlp_req, tlp_data, tlp_valid, tlp_sop, tlp_eop,
    output tlp_ack,
    input  dllp_req, dllp_data, dllp_valid, dllp_sop, dllp_eop,
    output dllp_ack,
    output lp_irdy, lp_data, lp_valid, lp_tlp_start, lp_tlp_end,
    output lp_dllp_start, lp_dllp_end, lp_tlpedb, tx_abort
  );

  modport slave (
    output pl_state_sts, pl_trdy,
    output tlp_req, tlp_data, tlp_valid, tlp_sop, tlp_eop,
    input  tlp_ack,
    output dllp_req, dllp_data, dllp_valid, dllp_sop, dllp_eop,
    input  dllp_ack,
    input  lp_irdy, lp_data, lp_valid, lp_tlp_start, lp_tlp_end,
    input  lp_dllp_start, lp_dllp_end, lp_tlpedb, tx_abort
  );
endinterface

// File: rtl/lpif_tx_arbiter.sv
// Packet-atomic TLP/DLLP scheduler onto the LPIF TX bus; accepted beat appears on lp_* one cycle later.
// Holds the output register while pl_trdy is low; acks are withheld until the register frees up.
module lpif_tx_arbiter #(
  parameter int BUS_WIDTH    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic               lclk,
  input logic               reset,
  lpif_tx_arbiter_if.master bus
);
  localparam int NB = BUS_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_DLLP, S_TLP} state_t;

  state_t               r_state;
  logic [3:0]           r_starve_cnt;
  logic                 r_tlp_pend;
  logic                 r_irdy;
  logic [BUS_WIDTH-1:0] r_data;
  logic [NB-1:0]        r_valid;
  logic [NB-1:0]        r_tlp_start;
  logic [NB-1:0]        r_tlp_end;
  logic [NB-1:0]        r_dllp_start;
  logic [NB-1:0]        r_dllp_end;
  logic                 r_tx_abort;

  logic w_active;
  logic w_link_rst;
  logic w_out_free;
  logic w_pick_tlp;
  logic w_take_tlp;
  logic w_take_dllp;
  logic w_dllp_tlp_pend;

  assign w_active   = (bus.pl_state_sts == 4'b0001);
  assign w_link_rst = (bus.pl_state_sts == 4'b0000);
  assign w_out_free = !r_irdy || bus.pl_trdy;
  assign w_pick_tlp = bus.tlp_req && (!bus.dllp_req || (r_starve_cnt == 4'(STARVE_LIMIT)));
  // A DLLP counts against the TLP only if the TLP was already waiting when the DLLP won.
  assign w_dllp_tlp_pend = (r_state == S_IDLE) ? bus.tlp_req : r_tlp_pend;

  always_comb begin
    w_take_tlp  = 1'b0;
    w_take_dllp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_active && w_out_free) begin
          if (w_pick_tlp)        w_take_tlp  = 1'b1;
          else if (bus.dllp_req) w_take_dllp = 1'b1;
        end
      end
      S_DLLP:  w_take_dllp = !w_link_rst && w_out_free && bus.dllp_req;
      S_TLP:   w_take_tlp  = !w_link_rst && w_out_free && bus.tlp_req;
      default: ;
    endcase
  end

  always_ff @(posedge lclk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= 4'd0;
      r_tlp_pend   <= 1'b0;
      r_irdy       <= 1'b0;
      r_data       <= '0;
      r_valid      <= '0;
      r_tlp_start  <= '0;
      r_tlp_end    <= '0;
      r_dllp_start <= '0;
      r_dllp_end   <= '0;
      r_tx_abort   <= 1'b0;
    end else begin
      r_tx_abort <= 1'b0;
      if (w_link_rst) begin
        // Once flushed the state is IDLE and the register empty, so held RESET cannot re-pulse.
        r_tx_abort   <= (r_state != S_IDLE) || r_irdy;
        r_state      <= S_IDLE;
        r_tlp_pend   <= 1'b0;
        r_irdy       <= 1'b0;
        r_data       <= '0;
        r_valid      <= '0;
        r_tlp_start  <= '0;
        r_tlp_end    <= '0;
        r_dllp_start <= '0;
        r_dllp_end   <= '0;
      end else if (w_take_tlp) begin
        r_irdy       <= 1'b1;
        r_data       <= bus.tlp_data;
        r_valid      <= bus.tlp_valid;
        r_tlp_start  <= bus.tlp_sop;
        r_tlp_end    <= bus.tlp_eop;
        r_dllp_start <= '0;
        r_dllp_end   <= '0;
        if (|bus.tlp_eop) begin
          r_state      <= S_IDLE;
          r_starve_cnt <= 4'd0;
        end else begin
          r_state <= S_TLP;
        end
      end else if (w_take_dllp) begin
        r_irdy       <= 1'b1;
        r_data       <= bus.dllp_data;
        r_valid      <= bus.dllp_valid;
        r_tlp_start  <= '0;
        r_tlp_end    <= '0;
        r_dllp_start <= bus.dllp_sop;
        r_dllp_end   <= bus.dllp_eop;
        if (|bus.dllp_eop) begin
          r_state <= S_IDLE;
          if (w_dllp_tlp_pend && (r_starve_cnt != 4'(STARVE_LIMIT)))
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end else begin
          r_state <= S_DLLP;
          if (r_state == S_IDLE) r_tlp_pend <= bus.tlp_req;
        end
      end else if (r_irdy && bus.pl_trdy) begin
        r_irdy       <= 1'b0;
        r_data       <= '0;
        r_valid      <= '0;
        r_tlp_start  <= '0;
        r_tlp_end    <= '0;
        r_dllp_start <= '0;
        r_dllp_end   <= '0;
      end
    end
  end

  assign bus.tlp_ack       = w_take_tlp;
  assign bus.dllp_ack      = w_take_dllp;
  assign bus.lp_irdy       = r_irdy;
  assign bus.lp_data       = r_data;
  assign bus.lp_valid      = r_valid;
  assign bus.lp_tlp_start  = r_tlp_start;
  assign bus.lp_tlp_end    = r_tlp_end;
  assign bus.lp_dllp_start = r_dllp_start;
  assign bus.lp_dllp_end   = r_dllp_end;
  assign bus.lp_tlpedb     = '0;
  assign bus.tx_abort      = r_tx_abort;
endmodule

// File: tb/tb_lpif_tx_arbiter.sv
// Scoreboard bench for lpif_tx_arbiter: directed packets feed source queues, expected PHY beats
// are queued in hand-derived order and checked by an independent monitor on every transfer.
`timescale 1ns/1ps
module tb_lpif_tx_arbiter;
  localparam int BW = 32;
  localparam int NB = BW / 8;

  typedef struct packed {
    logic [BW-1:0] d;
    logic [NB-1:0] v, sop, eop;
  } beat_t;

  typedef struct packed {
    logic [BW-1:0] d;
    logic [NB-1:0] v, ts, te, ds, de, edb;
  } obeat_t;

  logic lclk = 1'b0;
  logic reset = 1'b1;
  always #5 lclk = ~lclk;

  lpif_tx_arbiter_if #(.BUS_WIDTH(BW)) bus ();
  lpif_tx_arbiter #(.BUS_WIDTH(BW), .STARVE_LIMIT(4)) dut (.lclk(lclk), .reset(reset), .bus(bus));

  beat_t  tq[$];
  beat_t  dq[$];
  obeat_t sb[$];
  int     ack_cyc[$];
  int     xfer_cyc[$];
  int     n_chk = 0, n_fail = 0;
  int     cyc = 0, tlp_acks = 0, dllp_acks = 0, abort_cnt = 0;

  always @(posedge lclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic add_pkt(input bit is_tlp, input logic [BW-1:0] base, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      beat_t b;
      b.d   = base + BW'(i);
      b.v   = 4'hF;
      b.sop = (i == 0) ? 4'b0001 : 4'b0000;
      b.eop = (i == nbeats - 1) ? 4'b1000 : 4'b0000;
      if (is_tlp) tq.push_back(b);
      else        dq.push_back(b);
    end
  endtask

  // Expect the first nexp beats of an nbeats packet on the PHY side.
  task automatic exp_pkt(input bit is_tlp, input logic [BW-1:0] base, input int nbeats, input int nexp);
    for (int i = 0; i < nexp; i++) begin
      obeat_t o;
      logic [NB-1:0] s, e;
      s = (i == 0) ? 4'b0001 : 4'b0000;
      e = (i == nbeats - 1) ? 4'b1000 : 4'b0000;
      o   = '0;
      o.d = base + BW'(i);
      o.v = 4'hF;
      if (is_tlp) begin o.ts = s; o.te = e; end
      else        begin o.ds = s; o.de = e; end
      sb.push_back(o);
    end
  endtask

  task automatic step();
    @(posedge lclk);
    #2;
  endtask

  task automatic drain(input string name, input int lim);
    int k = 0;
    while ((sb.size() != 0 || tq.size() != 0 || dq.size() != 0 || bus.lp_irdy) && k < lim) begin
      step();
      k++;
    end
    if (k >= lim) timeout_fail(name);
    repeat (2) step();
  endtask

  task automatic wait_tlp_acks(input string name, input int target, input int lim);
    int k = 0;
    while (tlp_acks < target && k < lim) begin
      step();
      k++;
    end
    if (tlp_acks < target) timeout_fail(name);
  endtask

  // Source driver: presents queue heads, advances on ack, drops queued beats on link abort.
  initial begin
    bit ta, da, ab;
    bus.tlp_req = 1'b0;  bus.tlp_data = '0;  bus.tlp_valid = '0;  bus.tlp_sop = '0;  bus.tlp_eop = '0;
    bus.dllp_req = 1'b0; bus.dllp_data = '0; bus.dllp_valid = '0; bus.dllp_sop = '0; bus.dllp_eop = '0;
    forever begin
      @(negedge lclk);
      ta = bus.tlp_ack;
      da = bus.dllp_ack;
      ab = bus.tx_abort;
      @(posedge lclk);
      #1;
      if (ta && tq.size() > 0) begin void'(tq.pop_front()); tlp_acks++; end
      if (da && dq.size() > 0) begin void'(dq.pop_front()); dllp_acks++; end
      if (ab) begin tq.delete(); dq.delete(); end
      if (tq.size() > 0) begin
        bus.tlp_req = 1'b1; bus.tlp_data = tq[0].d; bus.tlp_valid = tq[0].v;
        bus.tlp_sop = tq[0].sop; bus.tlp_eop = tq[0].eop;
      end else begin
        bus.tlp_req = 1'b0; bus.tlp_data = '0; bus.tlp_valid = '0; bus.tlp_sop = '0; bus.tlp_eop = '0;
      end
      if (dq.size() > 0) begin
        bus.dllp_req = 1'b1; bus.dllp_data = dq[0].d; bus.dllp_valid = dq[0].v;
        bus.dllp_sop = dq[0].sop; bus.dllp_eop = dq[0].eop;
      end else begin
        bus.dllp_req = 1'b0; bus.dllp_data = '0; bus.dllp_valid = '0; bus.dllp_sop = '0; bus.dllp_eop = '0;
      end
    end
  end

  // Monitor: every PHY transfer is matched against the scoreboard head.
  always @(negedge lclk) begin
    if (!reset) begin
      if (bus.tx_abort) abort_cnt++;
      if (bus.tlp_ack || bus.dllp_ack) ack_cyc.push_back(cyc);
      if (bus.pl_state_sts == 4'b0000) check("ack_in_link_reset", {bus.tlp_ack, bus.dllp_ack}, 0);
      if (bus.lp_irdy && bus.pl_trdy) begin
        obeat_t a;
        xfer_cyc.push_back(cyc);
        a = {bus.lp_data, bus.lp_valid, bus.lp_tlp_start, bus.lp_tlp_end,
             bus.lp_dllp_start, bus.lp_dllp_end, bus.lp_tlpedb};
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat", a);
        end else begin
          check("beat", 64'(a), 64'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acks, base_abort, base_dllp;
    bus.pl_state_sts = 4'b0001;
    bus.pl_trdy      = 1'b1;

    // Reset values
    repeat (3) @(negedge lclk);
    check("rst_lp_irdy", bus.lp_irdy, 0);
    check("rst_lp_data", bus.lp_data, 0);
    check("rst_lp_valid", bus.lp_valid, 0);
    check("rst_masks", {bus.lp_tlp_start, bus.lp_tlp_end, bus.lp_dllp_start, bus.lp_dllp_end, bus.lp_tlpedb}, 0);
    check("rst_acks", {bus.tlp_ack, bus.dllp_ack}, 0);
    check("rst_tx_abort", bus.tx_abort, 0);
    step();
    reset = 1'b0;
    repeat (2) step();

    // Single 3-beat TLP: consecutive acks, each beat on the bus one cycle after its ack
    ack_cyc.delete();
    xfer_cyc.delete();
    add_pkt(1, 32'hA000_0000, 3);
    exp_pkt(1, 32'hA000_0000, 3, 3);
    drain("t1_drain", 50);
    check("t1_ack_count", ack_cyc.size(), 3);
    check("t1_xfer_count", xfer_cyc.size(), 3);
    if (ack_cyc.size() == 3 && xfer_cyc.size() == 3) begin
      check("t1_ack_span", ack_cyc[2] - ack_cyc[0], 2);
      for (int i = 0; i < 3; i++) check("t1_latency", xfer_cyc[i] - ack_cyc[i], 1);
    end

    // Starvation: 4 DLLPs win, then the waiting TLP, then remaining DLLPs
    for (int i = 0; i < 6; i++) add_pkt(0, 32'hD000_0000 + 32'(i * 16), 1);
    add_pkt(1, 32'hB000_0000, 1);
    for (int i = 0; i < 4; i++) exp_pkt(0, 32'hD000_0000 + 32'(i * 16), 1, 1);
    exp_pkt(1, 32'hB000_0000, 1, 1);
    for (int i = 4; i < 6; i++) exp_pkt(0, 32'hD000_0000 + 32'(i * 16), 1, 1);
    drain("t2a_drain", 100);

    // Counter restarted from 0: again exactly 4 (multi-beat) DLLPs before the TLP
    for (int i = 0; i < 5; i++) add_pkt(0, 32'hD100_0000 + 32'(i * 16), 2);
    add_pkt(1, 32'hB100_0000, 1);
    for (int i = 0; i < 4; i++) exp_pkt(0, 32'hD100_0000 + 32'(i * 16), 2, 2);
    exp_pkt(1, 32'hB100_0000, 1, 1);
    exp_pkt(0, 32'hD100_0000 + 32'(4 * 16), 2, 2);
    drain("t2b_drain", 100);

    // PHY stall mid-TLP: beat held, ack withheld
    base_acks = tlp_acks;
    add_pkt(1, 32'hC000_0000, 3);
    exp_pkt(1, 32'hC000_0000, 3, 3);
    wait_tlp_acks("t3_wait", base_acks + 1, 20);
    bus.pl_trdy = 1'b0;
    repeat (5) begin
      @(negedge lclk);
      check("t3_stall_irdy", bus.lp_irdy, 1);
      check("t3_stall_data", bus.lp_data, 32'hC000_0000);
      check("t3_stall_ack", bus.tlp_ack, 0);
    end
    step();
    bus.pl_trdy = 1'b1;
    drain("t3_drain", 50);
    check("t3_acks", tlp_acks - base_acks, 3);

    // DLLP arriving mid-TLP waits for the TLP end
    base_acks = tlp_acks;
    add_pkt(1, 32'hE000_0000, 3);
    exp_pkt(1, 32'hE000_0000, 3, 3);
    exp_pkt(0, 32'hD200_0000, 1, 1);
    wait_tlp_acks("t4_wait", base_acks + 1, 20);
    add_pkt(0, 32'hD200_0000, 1);
    drain("t4_drain", 50);

    // Link reset on beat 2 of a 4-beat TLP
    base_acks  = tlp_acks;
    base_abort = abort_cnt;
    add_pkt(1, 32'hF000_0000, 4);
    exp_pkt(1, 32'hF000_0000, 4, 2);
    wait_tlp_acks("t5_wait", base_acks + 2, 20);
    bus.pl_state_sts = 4'b0000;
    step();
    check("t5_irdy_cleared", bus.lp_irdy, 0);
    check("t5_abort_pulse", bus.tx_abort, 1);
    repeat (3) step();
    base_dllp = dllp_acks;
    add_pkt(0, 32'hD300_0000, 1);
    exp_pkt(0, 32'hD300_0000, 1, 1);
    repeat (3) step();
    check("t5_abort_once", abort_cnt - base_abort, 1);
    check("t5_no_grant", dllp_acks - base_dllp, 0);
    check("t5_irdy_idle", bus.lp_irdy, 0);
    check("t5_tlp_beats", tlp_acks - base_acks, 2);
    bus.pl_state_sts = 4'b0001;
    drain("t5_drain", 50);
    check("t5_dllp_sent", dllp_acks - base_dllp, 1);

    // Non-ACTIVE PHY state blocks new packets; start follows ACTIVE immediately
    bus.pl_state_sts = 4'b0100;
    add_pkt(1, 32'h9000_0000, 1);
    exp_pkt(1, 32'h9000_0000, 1, 1);
    repeat (4) begin
      @(negedge lclk);
      check("t6_hold_ack", bus.tlp_ack, 0);
      check("t6_hold_irdy", bus.lp_irdy, 0);
    end
    step();
    bus.pl_state_sts = 4'b0001;
    @(negedge lclk);
    check("t6_start_ack", bus.tlp_ack, 1);
    @(negedge lclk);
    check("t6_start_irdy", bus.lp_irdy, 1);
    step();
    drain("t6_drain", 50);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
